// File: rtl/pulse_shortening_device_pkg.sv
// Shared constants and helpers for the pulse shortener: legal parameter
// ranges and the width of the output-length counter.
package pulse_shortening_device_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int OUT_WIDTH_MIN   = 1;
  localparam int OUT_WIDTH_MAX   = 255;

  // Bits needed to hold every value from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/pulse_shortening_device_sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; every stage clears
// on asynchronous active-low reset.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_p0 <= '0;
    end else begin
      chain_p0 <= {chain_p0[STAGES-2:0], d};
    end
  end

  assign q = chain_p0[STAGES-1];

endmodule

// File: rtl/pulse_shortening_device.sv
// Turns every rising edge of an asynchronous input into one fixed-length,
// non-retriggerable output pulse counted in clock cycles.
module pulse_shortening_device
  import pulse_shortening_device_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int OUT_WIDTH_CYCLES = 1
) (
  input  logic IN_CLOCK,
  input  logic IN_RESET_N,
  input  logic IN_PULSE,
  output logic OUT_SHORT_PULSE
);

  localparam int              CNT_W    = cnt_width(OUT_WIDTH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OUT_WIDTH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("pulse_shortening_device: SYNC_STAGES must be 2..4");
  end
  if (OUT_WIDTH_CYCLES < OUT_WIDTH_MIN || OUT_WIDTH_CYCLES > OUT_WIDTH_MAX) begin : g_bad_width
    $error("pulse_shortening_device: OUT_WIDTH_CYCLES must be 1..255");
  end

  logic             s_p0;
  logic             s_p1;
  logic             rise_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Stage 0: synchronized input sample
  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (IN_CLOCK),
    .rst_n (IN_RESET_N),
    .d     (IN_PULSE),
    .q     (s_p0)
  );

  assign rise_p1 = s_p0 & ~s_p1;

  // Stage 1: edge detect, width counter and registered output.
  // The output flop mirrors (counter != 0) directly, so the pulse appears in
  // the same cycle the counter loads rather than one cycle later.
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      s_p1            <= 1'b0;
      cnt_p1          <= '0;
      OUT_SHORT_PULSE <= 1'b0;
    end else begin
      s_p1 <= s_p0;
      if (rise_p1 && cnt_p1 == '0) begin
        cnt_p1          <= CNT_LOAD;
        OUT_SHORT_PULSE <= 1'b1;
      end else if (cnt_p1 != '0) begin
        cnt_p1          <= cnt_p1 - CNT_ONE;
        OUT_SHORT_PULSE <= (cnt_p1 != CNT_ONE);
      end
    end
  end

endmodule

// File: tb/tb_pulse_shortening_device.sv
// Bench for pulse_shortening_device: directed timing table, reset-mid-pulse
// sequence and randomized inputs against a sample-history reference model.
module tb_pulse_shortening_device;

  localparam int NV = 42;
  localparam int NR = 600;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic p_a, p_b, p_c;
  logic o_a, o_b, o_c;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit pa;
    bit ga;
    bit pb;
    bit ea;
    bit eb;
  } vec_t;

  vec_t tbl [NV];

  bit hist_a[$];
  bit hist_b[$];
  bit hist_c[$];

  pulse_shortening_device #(.SYNC_STAGES(2), .OUT_WIDTH_CYCLES(1)) dut_a (
    .IN_CLOCK(clk), .IN_RESET_N(rst_a), .IN_PULSE(p_a), .OUT_SHORT_PULSE(o_a));
  pulse_shortening_device #(.SYNC_STAGES(2), .OUT_WIDTH_CYCLES(4)) dut_b (
    .IN_CLOCK(clk), .IN_RESET_N(rst_b), .IN_PULSE(p_b), .OUT_SHORT_PULSE(o_b));
  pulse_shortening_device #(.SYNC_STAGES(3), .OUT_WIDTH_CYCLES(5)) dut_c (
    .IN_CLOCK(clk), .IN_RESET_N(rst_c), .IN_PULSE(p_c), .OUT_SHORT_PULSE(o_c));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: an input sample taken at edge m reaches the edge detector S
  // edges later; a detected rise at edge j is accepted only if the previous
  // window of W output cycles ended strictly before j.
  function automatic bit model_out(input bit h[$], input int j, input int S,
                                   input int W, inout int last);
    bit cur;
    bit prv;
    cur = (j - S >= 0)     ? h[j - S]     : 1'b0;
    prv = (j - S - 1 >= 0) ? h[j - S - 1] : 1'b0;
    if (cur && !prv && j > last + W) last = j;
    return (j >= last) && (j < last + W);
  endfunction

  initial begin
    int  last_a, last_b, last_c;
    bit  ra, rb, rc;

    for (int k = 5; k <= 9; k++) tbl[k].pa = 1'b1;
    tbl[14].pa = 1'b1;
    tbl[19].ga = 1'b1;
    for (int k = 22; k <= 30; k += 2) tbl[k].pa = 1'b1;
    tbl[7].ea = 1'b1;
    tbl[16].ea = 1'b1;
    for (int k = 24; k <= 32; k += 2) tbl[k].ea = 1'b1;
    tbl[5].pb = 1'b1;
    tbl[8].pb = 1'b1;
    for (int k = 14; k <= 25; k++) tbl[k].pb = 1'b1;
    for (int k = 7; k <= 10; k++) tbl[k].eb = 1'b1;
    for (int k = 16; k <= 19; k++) tbl[k].eb = 1'b1;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    p_a = 1'b0; p_b = 1'b0; p_c = 1'b0;
    #3;
    check("reset_a", o_a, 1'b0);
    check("reset_b", o_b, 1'b0);
    check("reset_c", o_c, 1'b0);
    #2;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #15;

    for (int k = 1; k < NV; k++) begin
      p_a = tbl[k].pa | tbl[k].ga;
      p_b = tbl[k].pb;
      #5;
      if (tbl[k].ga) p_a = 1'b0;
      #10;
      check($sformatf("table_a[%0d]", k), o_a, tbl[k].ea);
      check($sformatf("table_b[%0d]", k), o_b, tbl[k].eb);
      #5;
    end

    // Reset asserted mid-pulse on the 4-cycle instance, input held high.
    #100 p_b = 1'b1;
    #55 check("rst_seq_before", o_b, 1'b1);
    #5 rst_b = 1'b0;
    #1 check("rst_seq_async_drop", o_b, 1'b0);
    #34 rst_b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #20 check($sformatf("rst_seq_after[%0d]", i), o_b, (i >= 2 && i <= 5));
    end
    p_b = 1'b0;

    p_a = 1'b0; p_b = 1'b0; p_c = 1'b0;
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    #5;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);

    last_a = -1000; last_b = -1000; last_c = -1000;
    ra = 1'b0; rb = 1'b0; rc = 1'b0;
    for (int j = 0; j < NR; j++) begin
      if ($urandom_range(0, 2) == 0) ra = ~ra;
      if ($urandom_range(0, 2) == 0) rb = ~rb;
      if ($urandom_range(0, 3) == 0) rc = ~rc;
      p_a = ra; p_b = rb; p_c = rc;
      hist_a.push_back(ra);
      hist_b.push_back(rb);
      hist_c.push_back(rc);
      #15;
      check($sformatf("rand_a[%0d]", j), o_a, model_out(hist_a, j, 2, 1, last_a));
      check($sformatf("rand_b[%0d]", j), o_b, model_out(hist_b, j, 2, 4, last_b));
      check($sformatf("rand_c[%0d]", j), o_c, model_out(hist_c, j, 3, 5, last_c));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
